// File: rtl/cpu_bus_pkg.sv
// Shared bus definitions for the CPU controller, the address mux and the memory responder.
package cpu_bus_pkg;

   localparam int unsigned BUS_AWIDTH = 5;
   localparam int unsigned BUS_DWIDTH = 8;

   // Controller sequencing phases
   localparam logic [2:0] PH_INST_ADDR  = 3'd0;
   localparam logic [2:0] PH_INST_FETCH = 3'd1;
   localparam logic [2:0] PH_INST_LOAD  = 3'd2;
   localparam logic [2:0] PH_IDLE       = 3'd3;
   localparam logic [2:0] PH_OP_ADDR    = 3'd4;
   localparam logic [2:0] PH_OP_FETCH   = 3'd5;
   localparam logic [2:0] PH_ALU_OP     = 3'd6;
   localparam logic [2:0] PH_STORE      = 3'd7;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RD_DATA = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Storage array: synchronous write on two ports (bus over init on collision), combinational read.
module mem_array
   import cpu_bus_pkg::*;
#(
   parameter int unsigned AWIDTH = BUS_AWIDTH,
   parameter int unsigned DWIDTH = BUS_DWIDTH
) (
   input  logic              clk_i,
   input  logic              bus_we_i,
   input  logic [AWIDTH-1:0] bus_addr_i,
   input  logic [DWIDTH-1:0] bus_data_i,
   input  logic              init_we_i,
   input  logic [AWIDTH-1:0] init_addr_i,
   input  logic [DWIDTH-1:0] init_data_i,
   input  logic [AWIDTH-1:0] rd_addr_i,
   output logic [DWIDTH-1:0] rd_data_o
);

   logic [DWIDTH-1:0] mem_q [2**AWIDTH];
   logic              init_blocked;

   assign init_blocked = bus_we_i && (bus_addr_i == init_addr_i);

   always_ff @(posedge clk_i) begin
      if (bus_we_i)
         mem_q[bus_addr_i] <= bus_data_i;
      if (init_we_i && !init_blocked)
         mem_q[init_addr_i] <= init_data_i;
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serves level-held rd after RD_WAIT wait states, commits wr strobes, flags misuse.
module mem_responder
   import cpu_bus_pkg::*;
#(
   parameter int unsigned AWIDTH  = BUS_AWIDTH,
   parameter int unsigned DWIDTH  = BUS_DWIDTH,
   parameter int unsigned RD_WAIT = 1
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic [AWIDTH-1:0] addr,
   input  logic              rd,
   input  logic              wr,
   input  logic              data_e,
   input  logic [DWIDTH-1:0] wdata,
   input  logic              init_we,
   input  logic [AWIDTH-1:0] init_addr,
   input  logic [DWIDTH-1:0] init_data,
   output logic [DWIDTH-1:0] rdata,
   output logic              rdata_valid,
   output logic              busy,
   output logic              err
);

   mem_state_e        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] rdata_q, rdata_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic              rd_q, wr_q;
   logic              rd_rise, wr_rise, bus_we;
   logic [AWIDTH-1:0] rd_addr;
   logic [DWIDTH-1:0] mem_rdata;

   assign rd_rise = rd & ~rd_q;
   assign wr_rise = wr & ~wr_q;
   // Zero-wait reads sample the live address on the rd edge; others use the latched one.
   assign rd_addr = (state_q == ST_IDLE) ? addr : addr_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rdata_d = rdata_q;
      valid_d = valid_q;
      err_d   = 1'b0;
      bus_we  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (rd_rise && wr_rise) begin
               err_d = 1'b1;
            end else if (rd_rise) begin
               addr_d = addr;
               if (RD_WAIT == 0) begin
                  state_d = ST_RD_DATA;
                  rdata_d = mem_rdata;
                  valid_d = 1'b1;
               end else begin
                  state_d = ST_RD_WAIT;
                  cnt_d   = 3'(RD_WAIT - 1);
               end
            end else if (wr_rise) begin
               if (data_e) bus_we = 1'b1;
               else        err_d  = 1'b1;
            end
         end
         ST_RD_WAIT: begin
            err_d = wr_rise;
            if (!rd) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = ST_RD_DATA;
               rdata_d = mem_rdata;
               valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_RD_DATA: begin
            err_d = wr_rise;
            if (!rd) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // rd_q resets high so a rd still held across reset release is not taken as a new request.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rdata_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rd_q    <= 1'b1;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         rd_q    <= rd;
         wr_q    <= wr;
      end
   end

   mem_array #(
      .AWIDTH(AWIDTH),
      .DWIDTH(DWIDTH)
   ) u_mem (
      .clk_i      (clk),
      .bus_we_i   (bus_we),
      .bus_addr_i (addr),
      .bus_data_i (wdata),
      .init_we_i  (init_we),
      .init_addr_i(init_addr),
      .init_data_i(init_data),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (mem_rdata)
   );

   assign rdata       = rdata_q;
   assign rdata_valid = valid_q;
   assign busy        = (state_q != ST_IDLE);
   assign err         = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: RD_WAIT=1 main instance plus RD_WAIT=0 and RD_WAIT=7 instances.
module tb_mem_responder;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst_;
   logic [AW-1:0] addr;
   logic          rd, wr, data_e;
   logic [DW-1:0] wdata;
   logic          init_we;
   logic [AW-1:0] init_addr;
   logic [DW-1:0] init_data;
   logic [DW-1:0] rdata, rdata0, rdata7;
   logic          rdata_valid, busy, err;
   logic          rd0, v0, b0, e0;
   logic          rd7, v7, b7, e7;

   logic [DW-1:0] exp_q [$];
   logic          v1_prev = 1'b0;
   int unsigned   n_chk  = 0;
   int unsigned   n_pass = 0;
   int            lat;

   always #5 clk = ~clk;

   mem_responder #(.AWIDTH(AW), .DWIDTH(DW), .RD_WAIT(1)) dut (
      .clk(clk), .rst_(rst_), .addr(addr), .rd(rd), .wr(wr), .data_e(data_e), .wdata(wdata),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
      .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .err(err)
   );

   mem_responder #(.AWIDTH(AW), .DWIDTH(DW), .RD_WAIT(0)) dut0 (
      .clk(clk), .rst_(rst_), .addr(addr), .rd(rd0), .wr(1'b0), .data_e(1'b0), .wdata(wdata),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
      .rdata(rdata0), .rdata_valid(v0), .busy(b0), .err(e0)
   );

   mem_responder #(.AWIDTH(AW), .DWIDTH(DW), .RD_WAIT(7)) dut7 (
      .clk(clk), .rst_(rst_), .addr(addr), .rd(rd7), .wr(1'b0), .data_e(1'b0), .wdata(wdata),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
      .rdata(rdata7), .rdata_valid(v7), .busy(b7), .err(e7)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Scoreboard: every rising rdata_valid on the main instance consumes one expected word.
   always @(negedge clk) begin
      if (rdata_valid === 1'b1 && !v1_prev) begin
         if (exp_q.size() == 0) check("sb_extra", 32'd1, 32'd0);
         else                   check("sb_rdata", rdata, exp_q.pop_front());
      end
      v1_prev <= (rdata_valid === 1'b1);
   end

   // All tasks are entered at a negedge and return at a negedge.
   task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
      init_we = 1'b1; init_addr = a; init_data = d;
      @(negedge clk);
      init_we = 1'b0;
   endtask

   task automatic read1(input logic [AW-1:0] a, input logic [DW-1:0] e, input int hold, input bit inj);
      addr = a; rd = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      check("busy_c1", busy, 1);
      check("valid_c1", rdata_valid, 0);
      if (inj) begin wr = 1'b1; data_e = 1'b1; wdata = 8'h77; end
      @(negedge clk);
      check("valid_c2", rdata_valid, 1);
      check("err_c2", err, 32'(inj));
      wr = 1'b0; data_e = 1'b0;
      repeat (hold) @(negedge clk);
      rd = 1'b0;
      @(negedge clk);
      check("valid_drop", rdata_valid, 0);
      check("busy_drop", busy, 0);
   endtask

   task automatic write1(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit de);
      addr = a; wdata = d; data_e = de; wr = 1'b1;
      @(negedge clk);
      check("wr_err", err, 32'(!de));
      wr = 1'b0; data_e = 1'b0;
      @(negedge clk);
      check("wr_err_end", err, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ = 1'b0; rd = 1'b0; wr = 1'b0; data_e = 1'b0; addr = '0; wdata = '0;
      init_we = 1'b0; init_addr = '0; init_data = '0; rd0 = 1'b0; rd7 = 1'b0;
      @(negedge clk);
      check("rst_rdata", rdata, 0);
      check("rst_valid", rdata_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      load(5'd3, 8'hA5);
      load(5'd7, 8'h00);
      load(5'd9, 8'h5A);
      load(5'd12, 8'hC3);
      rst_ = 1'b1;
      @(negedge clk);

      read1(5'd3, 8'hA5, 2, 1'b0);
      write1(5'd7, 8'h3C, 1'b1);
      read1(5'd7, 8'h3C, 1, 1'b0);
      write1(5'd7, 8'hFF, 1'b0);
      read1(5'd7, 8'h3C, 0, 1'b0);

      // wr held for several cycles writes only the first word
      addr = 5'd5; wdata = 8'h44; data_e = 1'b1; wr = 1'b1;
      @(negedge clk); wdata = 8'h55;
      @(negedge clk); wdata = 8'h66;
      @(negedge clk); wr = 1'b0; data_e = 1'b0;
      @(negedge clk);
      read1(5'd5, 8'h44, 0, 1'b0);

      // bus write beats init write to the same address
      addr = 5'd20; wdata = 8'hB2; data_e = 1'b1; wr = 1'b1;
      init_we = 1'b1; init_addr = 5'd20; init_data = 8'hE4;
      @(negedge clk);
      wr = 1'b0; data_e = 1'b0; init_we = 1'b0;
      @(negedge clk);
      read1(5'd20, 8'hB2, 0, 1'b0);

      // simultaneous rd and wr rise
      addr = 5'd9; wdata = 8'h11; data_e = 1'b1; rd = 1'b1; wr = 1'b1;
      @(negedge clk);
      check("sim_err", err, 1);
      check("sim_busy", busy, 0);
      wr = 1'b0; data_e = 1'b0;
      @(negedge clk);
      check("sim_busy2", busy, 0);
      check("sim_err_end", err, 0);
      rd = 1'b0;
      @(negedge clk);
      read1(5'd9, 8'h5A, 1, 1'b0);

      // wr during RD_WAIT: error, read finishes with old data, no write
      read1(5'd3, 8'hA5, 1, 1'b1);
      read1(5'd3, 8'hA5, 0, 1'b0);

      // async reset mid-read, rd held through release
      addr = 5'd3; rd = 1'b1;
      @(negedge clk);
      check("rr_busy_pre", busy, 1);
      rst_ = 1'b0;
      #1;
      check("rr_busy_async", busy, 0);
      check("rr_valid_async", rdata_valid, 0);
      @(negedge clk);
      rst_ = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rr_held_busy", busy, 0);
      end
      check("rr_held_valid", rdata_valid, 0);
      rd = 1'b0;
      @(negedge clk);
      read1(5'd3, 8'hA5, 1, 1'b0);

      // RD_WAIT=0 instance
      addr = 5'd3; rd0 = 1'b1;
      @(negedge clk);
      check("w0_valid", v0, 1);
      check("w0_rdata", rdata0, 32'hA5);
      check("w0_busy", b0, 1);
      rd0 = 1'b0;
      @(negedge clk);
      check("w0_drop", v0, 0);

      // RD_WAIT=7 instance: abort during wait, then full latency
      addr = 5'd12; rd7 = 1'b1;
      repeat (3) @(negedge clk);
      check("w7_busy", b7, 1);
      check("w7_novalid", v7, 0);
      rd7 = 1'b0;
      @(negedge clk);
      check("w7_abort_err", e7, 1);
      check("w7_abort_busy", b7, 0);
      check("w7_abort_valid", v7, 0);
      @(negedge clk);
      check("w7_err_end", e7, 0);

      rd7 = 1'b1; lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (v7 && lat == 0) lat = i;
      end
      check("w7_latency", 32'(lat), 8);
      check("w7_rdata", rdata7, 32'hC3);
      rd7 = 1'b0;
      @(negedge clk);
      check("w7_drop", v7, 0);

      check("sb_drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
